// File: rtl/bit32_exec_wb.sv
// -----------------------------------------------------------------------------
// bit32_exec_wb
//
// Execute/writeback stage placed directly after the 32x32 register file. It
// takes the two read-port operands, a decoded opcode and a destination
// register, computes a 32-bit result, and drives the register file write port.
// Logic and arithmetic ops finish in one cycle. MUL runs a 32-iteration
// shift-add loop.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   issue       start request, accepted only while idle (busy=0)
//   op[2:0]     000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed),
//               101 SLL by opb[4:0], 110 MUL (low 32 bits), 111 NOP
//   rd[4:0]     destination register
//   opa, opb    operands from register file read ports 1 and 2
//   busy        operation in flight; issue is ignored while high
//   regwrite    one-cycle registered write strobe (never for r0 or NOP)
//   write_addr  destination address, valid with regwrite
//   write_dat   result, valid with regwrite
//   zero        write_dat == 0, registered alongside write_dat
//   ovf         signed overflow for ADD/SUB, 0 for every other op
// -----------------------------------------------------------------------------
module bit32_exec_wb #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [2:0]       op,
    input  logic [4:0]       rd,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             regwrite,
    output logic [4:0]       write_addr,
    output logic [WIDTH-1:0] write_dat,
    output logic             zero,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] LAST_ITER = CW'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b100,
        OP_SLL = 3'b101,
        OP_MUL = 3'b110,
        OP_NOP = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         rd_q, rd_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               regwrite_q, regwrite_d;
    logic [4:0]         waddr_q, waddr_d;
    logic [WIDTH-1:0]   wdat_q, wdat_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   acc_step;

    assign sum  = opa + opb;
    assign diff = opa - opb;

    // The accumulator deliberately keeps only the low WIDTH bits, so signed and
    // unsigned operands produce the same product.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle datapath works on the live operands, because the result is
    // registered on the same edge that accepts the operation.
    always_comb begin
        // NOTE: every output of a combinational block is defaulted first, so
        // no path through the case leaves it unassigned and infers a latch.
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                alu_res = sum;
                // Operands of equal sign whose sum changes sign.
                alu_ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                // Operands of opposite sign whose difference takes opb's sign.
                alu_ovf = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            OP_SLT: alu_res[0] = $signed(opa) < $signed(opb);
            OP_SLL: alu_res = opa << opb[SHW-1:0];
            default: alu_res = '0;  // MUL goes through the iterative path; NOP yields 0
        endcase
    end

    // Next-state and output logic. The write-port outputs hold their values
    // unless a result is being produced on this edge.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        waddr_d    = waddr_q;
        wdat_d     = wdat_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        regwrite_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    if (op_t'(op) == OP_MUL) begin
                        mcand_d  = opa;
                        mplier_d = opb;
                        acc_d    = '0;
                        cnt_d    = '0;
                        rd_d     = rd;
                        state_d  = S_MUL;
                    end else begin
                        waddr_d    = rd;
                        wdat_d     = alu_res;
                        zero_d     = (alu_res == '0);
                        ovf_d      = alu_ovf;
                        regwrite_d = (rd != 5'd0) && (op_t'(op) != OP_NOP);
                        state_d    = S_WB;
                    end
                end
            end

            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // The last iteration's sum goes straight to the write port, so
                // the write strobe comes on the same edge the loop ends.
                if (cnt_q == LAST_ITER) begin
                    waddr_d    = rd_q;
                    wdat_d     = acc_step;
                    zero_d     = (acc_step == '0);
                    ovf_d      = 1'b0;
                    regwrite_d = (rd_q != 5'd0);
                    state_d    = S_WB;
                end
            end

            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Asynchronous reset also drops regwrite at once. A reset during MUL or
    // WB therefore never produces a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_q       <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdat_q     <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // register samples the pre-edge values and ordering does not matter.
            state_q    <= state_d;
            rd_q       <= rd_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdat_q     <= wdat_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign regwrite   = regwrite_q;
    assign write_addr = waddr_q;
    assign write_dat  = wdat_q;
    assign zero       = zero_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_bit32_exec_wb.sv
// -----------------------------------------------------------------------------
// tb_bit32_exec_wb
//
// Self-checking bench for bit32_exec_wb. Expected results come from a
// behavioural model built on plain 64-bit arithmetic. Directed cases cover
// ADD, SUB overflow, SLT, MUL, write suppression, reset during MUL, SLL and
// back-to-back issue. A randomized loop follows.
// -----------------------------------------------------------------------------
module tb_bit32_exec_wb;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                           SLT = 3'b100, SLL = 3'b101, MUL = 3'b110, NOP = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] opa, opb;
    logic        busy, regwrite, zero, ovf;
    logic [4:0]  write_addr;
    logic [31:0] write_dat;

    int n_checks = 0;
    int n_errors = 0;

    bit32_exec_wb dut (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .op         (op),
        .rd         (rd),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .regwrite   (regwrite),
        .write_addr (write_addr),
        .write_dat  (write_dat),
        .zero       (zero),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: results come from wide signed arithmetic, with no
    // bit-level tricks.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic ov);
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        ov  = 1'b0;
        case (o)
            ADD: begin s = sa + sb; res = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            SUB: begin s = sa - sb; res = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            AND_: res = a & b;
            OR_:  res = a | b;
            SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
            SLL:  res = a << b[4:0];
            MUL:  begin p = {32'd0, a} * {32'd0, b}; res = p[31:0]; end
            default: res = '0;
        endcase
    endfunction

    // Issues one op and follows it cycle by cycle until the DUT is idle again.
    // If poke is set, an ADD to r4 is presented during MUL and must be dropped.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [4:0] r,
                          input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] res;
        logic        ov;
        logic        wr;
        model(o, a, b, res, ov);
        wr = (r != 5'd0) && (o != NOP);
        @(negedge clk);
        op = o; rd = r; opa = a; opb = b; issue = 1'b1;
        @(posedge clk);
        #1;
        // Operands are captured on the accepting edge, so scramble them.
        issue = 1'b0; op = 3'($urandom); rd = 5'($urandom); opa = $urandom; opb = $urandom;
        if (o == MUL) begin
            check({tag, " busy@N"}, 32'(busy), 32'd1);
            check({tag, " nowrite@N"}, 32'(regwrite), 32'd0);
            for (int i = 1; i < 32; i++) begin
                @(posedge clk);
                #1;
                if (poke && i == 4) begin op = ADD; rd = 5'd4; opa = 32'd1; opb = 32'd1; issue = 1'b1; end
                if (poke && i == 5) issue = 1'b0;
                check({tag, " mul busy"}, 32'(busy), 32'd1);
                check({tag, " mul nowrite"}, 32'(regwrite), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        check({tag, " wb busy"}, 32'(busy), 32'd1);
        check({tag, " wb regwrite"}, 32'(regwrite), 32'(wr));
        if (wr) check({tag, " wb addr"}, 32'(write_addr), 32'(r));
        if (o != NOP) begin
            check({tag, " wb dat"}, write_dat, res);
            check({tag, " wb zero"}, 32'(zero), 32'(res == 32'd0));
        end
        check({tag, " wb ovf"}, 32'(ovf), 32'(ov));
        @(posedge clk);
        #1;
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle regwrite"}, 32'(regwrite), 32'd0);
        if (o != NOP) check({tag, " hold dat"}, write_dat, res);
        if (poke) begin
            @(posedge clk);
            #1;
            check({tag, " poke not queued"}, 32'(regwrite), 32'd0);
            check({tag, " poke idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [31:0] res;
        logic        ov;

        rst = 1'b1; issue = 1'b0; op = '0; rd = '0; opa = '0; opb = '0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset regwrite", 32'(regwrite), 32'd0);
        check("reset addr", 32'(write_addr), 32'd0);
        check("reset dat", write_dat, 32'd0);
        check("reset zero", 32'(zero), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add", ADD, 5'd3, 32'd5, 32'd7, 1'b0);
        run_op("sub ovf", SUB, 5'd1, 32'h8000_0000, 32'd1, 1'b0);
        run_op("slt", SLT, 5'd2, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("mul", MUL, 5'd9, 32'd1234, 32'd5678, 1'b1);
        run_op("mul neg", MUL, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("add r0", ADD, 5'd0, 32'd0, 32'd0, 1'b0);
        run_op("nop", NOP, 5'd7, 32'd3, 32'd4, 1'b0);
        run_op("add ovf", ADD, 5'd8, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op("mul r0", MUL, 5'd0, 32'd3, 32'd3, 1'b0);

        // Reset ten cycles into a MUL aborts it without any write.
        @(negedge clk);
        op = MUL; rd = 5'd11; opa = 32'd99; opb = 32'd77; issue = 1'b1;
        @(posedge clk);
        #1 issue = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst regwrite", 32'(regwrite), 32'd0);
        check("rst addr", 32'(write_addr), 32'd0);
        check("rst dat", write_dat, 32'd0);
        check("rst zero", 32'(zero), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (regwrite !== 1'b0) check("rst no write", 32'(regwrite), 32'd0);
        end
        check("rst stays idle", 32'(busy), 32'd0);
        run_op("add after rst", ADD, 5'd2, 32'd1, 32'd1, 1'b0);

        // SLL, then AND held on issue: AND is accepted at the first idle edge.
        @(negedge clk);
        op = SLL; rd = 5'd5; opa = 32'd1; opb = 32'h0000_0025; issue = 1'b1;
        @(posedge clk);
        #1;
        op = AND_; rd = 5'd6; opa = 32'hF0F0_1234; opb = 32'h0FF0_FF00;
        check("sll regwrite", 32'(regwrite), 32'd1);
        check("sll addr", 32'(write_addr), 32'd5);
        check("sll dat", write_dat, 32'h0000_0020);
        @(posedge clk);
        #1;
        check("b2b wb ignored", 32'(regwrite), 32'd0);
        check("b2b idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        issue = 1'b0;
        model(AND_, 32'hF0F0_1234, 32'h0FF0_FF00, res, ov);
        check("b2b and regwrite", 32'(regwrite), 32'd1);
        check("b2b and addr", 32'(write_addr), 32'd6);
        check("b2b and dat", write_dat, res);
        @(posedge clk);
        #1;
        check("b2b done", 32'(busy), 32'd0);

        // Randomized ops, with boundary operand values mixed in.
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = 32'h7FFF_FFFF;
                2: rb = ra;
                default: ;
            endcase
            run_op("rand", ro, 5'($urandom), ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
